// File: rtl/softusb_portctl_if.sv
// softusb_portctl_if: port-controller bus between the serialiser,
// the host logic and the per-port line drivers.
interface softusb_portctl_if #(
  parameter int NPORTS = 2,
  parameter int PW     = 1
);
  logic [2*NPORTS-1:0] line_state;
  logic                txp;
  logic                txm;
  logic                txoe;
  logic [PW-1:0]       tx_port;
  logic                tx_valid;
  logic                generate_eop;
  logic [NPORTS-1:0]   reset_req;
  logic [NPORTS-1:0]   port_vp;
  logic [NPORTS-1:0]   port_vm;
  logic [NPORTS-1:0]   port_oe;
  logic [NPORTS-1:0]   connected;
  logic [NPORTS-1:0]   low_speed;
  logic [NPORTS-1:0]   reset_active;
  logic [NPORTS-1:0]   status_chg;
  logic                tx_busy;

  modport master (
    output line_state, txp, txm, txoe, tx_port,
    output tx_valid, generate_eop, reset_req,
    input  port_vp, port_vm, port_oe,
    input  connected, low_speed, reset_active,
    input  status_chg, tx_busy
  );

  modport slave (
    input  line_state, txp, txm, txoe, tx_port,
    input  tx_valid, generate_eop, reset_req,
    output port_vp, port_vm, port_oe,
    output connected, low_speed, reset_active,
    output status_chg, tx_busy
  );
endinterface

// File: rtl/softusb_portctl.sv
// softusb_portctl: downstream port attach detection, timed bus
// reset and transmit steering for a multi-port soft USB host.
module softusb_portctl #(
  parameter int NPORTS    = 2,
  parameter int PW        = 1,
  parameter int DEBOUNCE  = 48000,
  parameter int RESET_LEN = 480000
) (
  input logic           usb_clk,
  input logic           usb_rst,
  softusb_portctl_if.slave bus
);

  localparam int CMAX =
    (DEBOUNCE > RESET_LEN) ? DEBOUNCE : RESET_LEN;
  localparam int CW = $clog2(CMAX);
  localparam logic [CW-1:0] DB_LOAD = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] RS_LOAD = CW'(RESET_LEN - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {
    S_DISC,
    S_DEB,
    S_CONN,
    S_RST
  } st_t;

  logic [NPORTS-1:0] conn_v;
  logic [NPORTS-1:0] ls_v;
  logic [NPORTS-1:0] chg_v;
  logic [NPORTS-1:0] ract_v;
  logic [NPORTS-1:0] oe_v;
  logic [NPORTS-1:0] vp_v;
  logic [NPORTS-1:0] vm_v;

  logic          txoe_q;
  logic          tx_fall_q;
  logic          busy_q;
  logic [PW-1:0] sel_q;
  logic          tx_rise;
  logic [PW-1:0] sel;

  // the rise cycle steers by tx_port directly, later cycles by the latch
  assign tx_rise = bus.txoe & ~txoe_q;
  assign sel     = tx_rise ? bus.tx_port : sel_q;

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      txoe_q    <= 1'b0;
      tx_fall_q <= 1'b0;
      busy_q    <= 1'b0;
      sel_q     <= '0;
    end else begin
      txoe_q    <= bus.txoe;
      tx_fall_q <= txoe_q & ~bus.txoe;
      if (tx_rise)
        sel_q <= bus.tx_port;
      if (bus.tx_valid | bus.generate_eop)
        busy_q <= 1'b1;
      else if (tx_fall_q)
        busy_q <= 1'b0;
    end
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    st_t           state;
    st_t           state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [1:0]    cand;
    logic [1:0]    cand_n;
    logic          conn_q;
    logic          conn_n;
    logic          ls_q;
    logic          ls_n;
    logic          ract_q;
    logic          chg_q;
    logic [1:0]    line;
    logic          idle;
    logic          se0;
    logic          freeze;

    assign line   = bus.line_state[2*i +: 2];
    assign idle   = (line == 2'b01) | (line == 2'b10);
    assign se0    = (line == 2'b00);
    assign freeze = oe_v[i] & (state != S_RST);

    always_ff @(posedge usb_clk) begin
      if (usb_rst) begin
        state <= S_DISC;
        cnt   <= '0;
        cand  <= 2'b00;
      end else begin
        state <= state_n;
        cnt   <= cnt_n;
        cand  <= cand_n;
      end
    end

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cand_n  = cand;
      if (bus.reset_req[i]) begin
        state_n = S_RST;
        cnt_n   = RS_LOAD;
      end else if (!freeze) begin
        unique case (state)
          S_DISC:
            if (idle) begin
              state_n = S_DEB;
              cand_n  = line;
              cnt_n   = DB_LOAD;
            end
          S_DEB:
            if (line != cand)
              state_n = S_DISC;
            else if (cnt == '0) begin
              state_n = S_CONN;
              cnt_n   = DB_LOAD;
            end else
              cnt_n = cnt - ONE;
          // counter measures an unbroken SE0 run
          S_CONN:
            if (!se0)
              cnt_n = DB_LOAD;
            else if (cnt == '0)
              state_n = S_DISC;
            else
              cnt_n = cnt - ONE;
          S_RST:
            if (cnt != '0)
              cnt_n = cnt - ONE;
            else if (idle) begin
              state_n = S_DEB;
              cand_n  = line;
              cnt_n   = DB_LOAD;
            end else
              state_n = S_DISC;
          default:
            state_n = S_DISC;
        endcase
      end
    end

    always_comb begin
      conn_n = conn_q;
      ls_n   = ls_q;
      if (state == S_DEB && state_n == S_CONN) begin
        conn_n = 1'b1;
        ls_n   = (cand == 2'b10);
      end else if (state != S_DISC && state_n == S_DISC) begin
        conn_n = 1'b0;
      end
    end

    always_ff @(posedge usb_clk) begin
      if (usb_rst) begin
        conn_q <= 1'b0;
        ls_q   <= 1'b0;
        ract_q <= 1'b0;
        chg_q  <= 1'b0;
      end else begin
        conn_q <= conn_n;
        ls_q   <= ls_n;
        ract_q <= (state_n == S_RST);
        chg_q  <= (conn_n != conn_q) | (ls_n != ls_q);
      end
    end

    assign oe_v[i]   = ract_q | (bus.txoe & (sel == PW'(i)));
    assign vp_v[i]   = ract_q ? 1'b0 : bus.txp;
    assign vm_v[i]   = ract_q ? 1'b0 : bus.txm;
    assign conn_v[i] = conn_q;
    assign ls_v[i]   = ls_q;
    assign ract_v[i] = ract_q;
    assign chg_v[i]  = chg_q;
  end

  assign bus.port_oe      = oe_v;
  assign bus.port_vp      = vp_v;
  assign bus.port_vm      = vm_v;
  assign bus.connected    = conn_v;
  assign bus.low_speed    = ls_v;
  assign bus.reset_active = ract_v;
  assign bus.status_chg   = chg_v;
  assign bus.tx_busy      = busy_q;

endmodule
